// File: rtl/tpu_host_driver_if.sv
// rtl/tpu_host_driver_if.sv - command, response and TPU operand/result bus bundle for the host driver
interface tpu_host_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        tpu_sync;
    logic        tpu_out_HL;
    logic [7:0]  tpu_input1;
    logic [7:0]  tpu_input2;
    logic        tpu_ready;
    logic        tpu_error;
    logic [15:0] tpu_out;
    logic [7:0]  err_count;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, rsp_ready, tpu_ready, tpu_error, tpu_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, tpu_sync, tpu_out_HL,
               tpu_input1, tpu_input2, err_count
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, rsp_ready, tpu_ready, tpu_error, tpu_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, tpu_sync, tpu_out_HL,
               tpu_input1, tpu_input2, err_count
    );
endinterface

// File: rtl/tpu_host_driver.sv
// rtl/tpu_host_driver.sv - buffers operand pairs, runs them through the TPU one at a time, returns results
module tpu_host_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    tpu_host_driver_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, RESP} state_t;

    state_t          state;
    logic [7:0]      mem_a [FIFO_DEPTH];
    logic [7:0]      mem_b [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [TO_W-1:0] to_cnt;

    logic            rsp_valid;
    logic [15:0]     rsp_data;
    logic            rsp_err;
    logic            tpu_sync;
    logic            tpu_out_HL;
    logic [7:0]      tpu_input1;
    logic [7:0]      tpu_input2;
    logic [7:0]      err_count;

    logic            cmd_ready;
    logic            push;
    logic            pop;
    logic            abort;
    logic            more_after_pop;
    logic [PW-1:0]   rd_next;
    logic [7:0]      next_a;
    logic [7:0]      next_b;

    assign cmd_ready = (count != (PW+1)'(FIFO_DEPTH));
    assign push      = bus.cmd_valid && cmd_ready;
    assign pop       = (state == RESP) && bus.rsp_ready;
    assign rd_next   = rd_ptr + PW'(1);

    // Error wins over a simultaneous ready; timeout only when the TPU stays silent.
    assign abort = bus.tpu_error || (!bus.tpu_ready && (to_cnt == TO_W'(TIMEOUT - 1)));

    // The follow-on command may be arriving in the very cycle the only queued one retires.
    assign more_after_pop = (count > (PW+1)'(1)) || push;
    assign next_a = (count > (PW+1)'(1)) ? mem_a[rd_next] : bus.cmd_a;
    assign next_b = (count > (PW+1)'(1)) ? mem_b[rd_next] : bus.cmd_b;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.cmd_a;
            mem_b[wr_ptr] <= bus.cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_next;
            if (push && !pop)      count <= count + (PW+1)'(1);
            else if (pop && !push) count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            to_cnt     <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            tpu_sync   <= 1'b0;
            tpu_out_HL <= 1'b0;
            tpu_input1 <= '0;
            tpu_input2 <= '0;
            err_count  <= '0;
        end else begin
            tpu_sync   <= 1'b0;
            tpu_out_HL <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state      <= ISSUE;
                        tpu_sync   <= 1'b1;
                        tpu_input1 <= mem_a[rd_ptr];
                        tpu_input2 <= mem_b[rd_ptr];
                    end
                end
                ISSUE: begin
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (abort) begin
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    end else if (bus.tpu_ready) begin
                        rsp_err    <= 1'b0;
                        rsp_data   <= bus.tpu_out;
                        tpu_out_HL <= 1'b1;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (more_after_pop) begin
                            state      <= ISSUE;
                            tpu_sync   <= 1'b1;
                            tpu_input1 <= next_a;
                            tpu_input2 <= next_b;
                        end else begin
                            state      <= IDLE;
                            tpu_input1 <= '0;
                            tpu_input2 <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data;
    assign bus.rsp_err    = rsp_err;
    assign bus.tpu_sync   = tpu_sync;
    assign bus.tpu_out_HL = tpu_out_HL;
    assign bus.tpu_input1 = tpu_input1;
    assign bus.tpu_input2 = tpu_input2;
    assign bus.err_count  = err_count;
endmodule

// File: tb/tb_tpu_host_driver.sv
// tb/tb_tpu_host_driver.sv - directed scoreboard bench for tpu_host_driver with a behavioural TPU
module tb_tpu_host_driver;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_sync = 0;
    int   n_hl = 0;
    int   tpu_mode = 0;   // 0 = ready with a*b after 3 cycles, 1 = error+ready together, 2 = silent
    logic prev_sync = 1'b0;
    logic prev_hl = 1'b0;
    logic [16:0] sb[$];

    tpu_host_driver_if bus ();

    tpu_host_driver #(.FIFO_DEPTH(4), .TIMEOUT(8), .TO_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_sync = 1'b0;
            prev_hl   = 1'b0;
        end else begin
            if (bus.tpu_sync) begin
                n_sync++;
                check("sync_width", prev_sync, 0);
            end
            if (bus.tpu_out_HL) begin
                n_hl++;
                check("hl_width", prev_hl, 0);
            end
            prev_sync = bus.tpu_sync;
            prev_hl   = bus.tpu_out_HL;
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    logic [16:0] e;
                    e = sb.pop_front();
                    check("rsp_data", bus.rsp_data, e[15:0]);
                    check("rsp_err", bus.rsp_err, e[16]);
                end
            end
        end
    end

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        bus.tpu_ready = 1'b0;
        bus.tpu_error = 1'b0;
        bus.tpu_out   = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.tpu_sync && tpu_mode != 2) begin
                a = bus.tpu_input1;
                b = bus.tpu_input2;
                repeat (3) @(posedge clk);
                #1;
                bus.tpu_ready = 1'b1;
                bus.tpu_error = (tpu_mode == 1);
                bus.tpu_out   = 16'(a) * 16'(b);
                @(posedge clk);
                #1;
                bus.tpu_ready = 1'b0;
                bus.tpu_error = 1'b0;
                bus.tpu_out   = '0;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int k;
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        k = 0;
        @(negedge clk);
        while (!bus.cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("cmd_accept", bus.cmd_ready, 1);
        sb.push_back((tpu_mode == 0) ? {1'b0, p} : {1'b1, 16'h0000});
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic check_reset_vals();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_sync", bus.tpu_sync, 0);
        check("rst_hl", bus.tpu_out_HL, 0);
        check("rst_in1", bus.tpu_input1, 0);
        check("rst_in2", bus.tpu_input2, 0);
        check("rst_err_count", bus.err_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int s0;
        int h0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_vals();

        // single operation with exact strobe timing
        tpu_mode = 0;
        bus.rsp_ready = 1'b1;
        s0 = n_sync;
        h0 = n_hl;
        send(8'h0D, 8'h0F);
        @(posedge clk); #1;
        check("single_sync", bus.tpu_sync, 1);
        check("single_in1", bus.tpu_input1, 8'h0D);
        check("single_in2", bus.tpu_input2, 8'h0F);
        repeat (3) @(posedge clk); #1;
        check("single_in1_held", bus.tpu_input1, 8'h0D);
        check("single_hl_early", bus.tpu_out_HL, 0);
        @(posedge clk); #1;
        check("single_hl", bus.tpu_out_HL, 1);
        @(posedge clk); #1;
        check("single_rsp_valid", bus.rsp_valid, 1);
        check("single_rsp_data", bus.rsp_data, 16'h00C3);
        drain();
        check("single_n_sync", n_sync - s0, 1);
        check("single_n_hl", n_hl - h0, 1);

        // fill the FIFO while responses are held off
        bus.rsp_ready = 1'b0;
        send(8'd1, 8'd2);
        send(8'd3, 8'd4);
        send(8'd5, 8'd6);
        send(8'd7, 8'd8);
        check("fill_full", bus.cmd_ready, 0);
        fork
            send(8'd9, 8'd10);
            begin
                repeat (20) @(posedge clk);
                #1;
                check("fill_still_full", bus.cmd_ready, 0);
                check("fill_rsp_waiting", bus.rsp_valid, 1);
                bus.rsp_ready = 1'b1;
            end
        join
        drain();

        // backpressure holds everything stable
        bus.rsp_ready = 1'b0;
        send(8'h31, 8'h05);
        k = 0;
        while (!bus.rsp_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        s0 = n_sync;
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_data", bus.rsp_data, 16'h00F5);
            check("bp_rsp_err", bus.rsp_err, 0);
            check("bp_in1", bus.tpu_input1, 8'h31);
            check("bp_in2", bus.tpu_input2, 8'h05);
            @(posedge clk); #1;
        end
        check("bp_no_sync", n_sync - s0, 0);
        bus.rsp_ready = 1'b1;
        drain();

        // error and ready together
        tpu_mode = 1;
        h0 = n_hl;
        send(8'h0A, 8'h0B);
        drain();
        check("err_no_hl", n_hl - h0, 0);
        check("err_count_1", bus.err_count, 1);

        // timeout: 8 silent WAIT cycles after the sync cycle
        tpu_mode = 2;
        send(8'h21, 8'h22);
        @(posedge clk); #1;
        check("to_sync", bus.tpu_sync, 1);
        k = 0;
        while (!bus.rsp_valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("to_latency", k, 9);
        check("to_rsp_err", bus.rsp_err, 1);
        check("to_err_count", bus.err_count, 2);
        drain();
        tpu_mode = 0;
        send(8'h11, 8'h12);
        drain();

        // reset while waiting with three commands queued
        tpu_mode = 2;
        bus.rsp_ready = 1'b0;
        send(8'd1, 8'd1);
        send(8'd2, 8'd2);
        send(8'd3, 8'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_vals();
        s0 = n_sync;
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_sync", n_sync - s0, 0);
        check("rst_idle_rsp", bus.rsp_valid, 0);
        tpu_mode = 0;
        bus.rsp_ready = 1'b1;
        send(8'h0D, 8'h0F);
        drain();
        check("post_rst_sync", n_sync - s0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
